// File: rtl/kpn_split_n.sv
// kpn_split_n: KPN fork process. Pops one token at a time from an input FIFO
// and writes it to N output FIFOs, either to every channel (MODE=0, broadcast)
// or to one channel chosen round-robin (MODE=1). Writes to full channels wait,
// so each token reaches each selected channel exactly once.
module kpn_split_n #(
    parameter int WIDTH = 16,
    parameter int N     = 2,
    parameter int MODE  = 0,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_empty,
    output logic                 in_rd,
    output logic [N*WIDTH-1:0]   out_data,
    input  logic [N-1:0]         out_full,
    output logic [N-1:0]         out_wr,
    output logic [CNT_W-1:0]     tok_cnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t               state_q,    state_d;
    logic                 in_rd_q,    in_rd_d;
    logic [N-1:0]         out_wr_q,   out_wr_d;
    logic [N*WIDTH-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]     tok_cnt_q,  tok_cnt_d;
    logic [WIDTH-1:0]     hold_q,     hold_d;
    logic [N-1:0]         pend_q,     pend_d;
    logic [PTR_W-1:0]     rr_ptr_q,   rr_ptr_d;

    // Channel mask for a freshly captured token: all channels when
    // broadcasting, otherwise only the channel the round-robin pointer selects.
    function automatic logic [N-1:0] select_mask(input logic [PTR_W-1:0] ptr);
        logic [N-1:0] m;
        m = '0;
        if (MODE == 0) begin
            m = '1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (ptr == PTR_W'(i)) begin
                    m[i] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    // Round-robin pointer advance, wrapping from channel N-1 back to 0.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] p;
        if (ptr == PTR_W'(N - 1)) begin
            p = '0;
        end else begin
            p = ptr + PTR_W'(1);
        end
        return p;
    endfunction

    // Next-state and registered-output logic for the pop/capture/send cycle.
    // A new pop is only requested once the held token has no pending channel,
    // so the FIFO never runs ahead of the writes.
    always_comb begin
        state_d    = state_q;
        in_rd_d    = 1'b0;
        out_wr_d   = '0;
        out_data_d = out_data_q;
        tok_cnt_d  = tok_cnt_q;
        hold_d     = hold_q;
        pend_d     = pend_q;
        rr_ptr_d   = rr_ptr_q;

        case (state_q)
            IDLE: begin
                if (!in_empty) begin
                    in_rd_d = 1'b1;
                    state_d = RD;
                end
            end

            RD: begin
                // The FIFO pops on this edge; its data is valid next cycle.
                state_d = CAP;
            end

            CAP: begin
                hold_d  = in_data;
                pend_d  = select_mask(rr_ptr_q);
                state_d = SEND;
            end

            SEND: begin
                for (int i = 0; i < N; i++) begin
                    if (pend_q[i] && !out_full[i]) begin
                        out_wr_d[i]                  = 1'b1;
                        out_data_d[i*WIDTH +: WIDTH] = hold_q;
                        pend_d[i]                    = 1'b0;
                    end
                end
                if (pend_d == '0) begin
                    tok_cnt_d = tok_cnt_q + CNT_W'(1);
                    if (MODE != 0) begin
                        rr_ptr_d = next_ptr(rr_ptr_q);
                    end
                    if (!in_empty) begin
                        in_rd_d = 1'b1;
                        state_d = RD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any held token and pending writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_rd_q    <= 1'b0;
            out_wr_q   <= '0;
            out_data_q <= '0;
            tok_cnt_q  <= '0;
            hold_q     <= '0;
            pend_q     <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            in_rd_q    <= in_rd_d;
            out_wr_q   <= out_wr_d;
            out_data_q <= out_data_d;
            tok_cnt_q  <= tok_cnt_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign in_rd    = in_rd_q;
    assign out_wr   = out_wr_q;
    assign out_data = out_data_q;
    assign tok_cnt  = tok_cnt_q;

endmodule

// File: tb/tb_kpn_split_n.sv
// Bench for kpn_split_n: a broadcast instance (N=2, CNT_W=4) and a round-robin
// instance (N=3), each fed by a small FIFO model. Stimulus queues expected
// tokens per channel; a monitor process compares every write and services
// scalar check requests posted by the stimulus.
module tb_kpn_split_n;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Broadcast instance
    logic [15:0] in_data_a = '0;
    logic        in_empty_a;
    logic        in_rd_a;
    logic [31:0] out_data_a;
    logic [1:0]  out_full_a = '0;
    logic [1:0]  out_wr_a;
    logic [3:0]  tok_cnt_a;

    // Round-robin instance
    logic [15:0] in_data_b = '0;
    logic        in_empty_b;
    logic        in_rd_b;
    logic [47:0] out_data_b;
    logic [2:0]  out_full_b = '0;
    logic [2:0]  out_wr_b;
    logic [15:0] tok_cnt_b;

    kpn_split_n #(.WIDTH(16), .N(2), .MODE(0), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_empty(in_empty_a),
        .in_rd(in_rd_a), .out_data(out_data_a), .out_full(out_full_a),
        .out_wr(out_wr_a), .tok_cnt(tok_cnt_a)
    );

    kpn_split_n #(.WIDTH(16), .N(3), .MODE(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_empty(in_empty_b),
        .in_rd(in_rd_b), .out_data(out_data_b), .out_full(out_full_b),
        .out_wr(out_wr_b), .tok_cnt(tok_cnt_b)
    );

    // Input FIFO models: stimulus appends to src_*, the model pops on in_rd.
    logic [15:0] src_a [0:63];
    logic [15:0] src_b [0:15];
    int avail_a  = 0;
    int avail_b  = 0;
    int rd_idx_a = 0;
    int rd_idx_b = 0;

    assign in_empty_a = (rd_idx_a >= avail_a);
    assign in_empty_b = (rd_idx_b >= avail_b);

    always @(posedge clk) begin
        if (in_rd_a) begin
            in_data_a <= src_a[rd_idx_a];
            rd_idx_a  <= rd_idx_a + 1;
        end
        if (in_rd_b) begin
            in_data_b <= src_b[rd_idx_b];
            rd_idx_b  <= rd_idx_b + 1;
        end
    end

    // Expected per-channel token streams (written by stimulus, read by monitor).
    logic [15:0] exp_a [0:1][0:63];
    logic [15:0] exp_b [0:2][0:15];
    int exp_n_a [2] = '{0, 0};
    int exp_n_b [3] = '{0, 0, 0};
    int rr_b = 0;

    // Check requests (stimulus -> monitor).
    int          req_seq  = 0;
    int          done_seq = 0;
    int          req_kind = 0;
    logic [63:0] req_exp  = '0;
    string       req_name = "";

    // Monitor-owned state.
    int n_vec = 0;
    int n_bad = 0;
    int rd_a [2] = '{0, 0};
    int rd_b [3] = '{0, 0, 0};
    int pops_a = 0;
    int since_a = 100;
    int last_gap_a = 0;

    initial begin
        logic [63:0] act;
        logic [15:0] got;
        int          rem;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                if (out_wr_a[c]) begin
                    got = out_data_a[c*16 +: 16];
                    n_vec++;
                    if (rd_a[c] >= exp_n_a[c]) begin
                        n_bad++;
                        $display("FAIL a_ch%0d_write: unexpected write of %h, none required", c, got);
                    end else begin
                        if (got !== exp_a[c][rd_a[c]]) begin
                            n_bad++;
                            $display("FAIL a_ch%0d_data: got %h, required %h", c, got, exp_a[c][rd_a[c]]);
                        end
                        rd_a[c]++;
                    end
                end
            end
            for (int c = 0; c < 3; c++) begin
                if (out_wr_b[c]) begin
                    got = out_data_b[c*16 +: 16];
                    n_vec++;
                    if (rd_b[c] >= exp_n_b[c]) begin
                        n_bad++;
                        $display("FAIL b_ch%0d_write: unexpected write of %h, none required", c, got);
                    end else begin
                        if (got !== exp_b[c][rd_b[c]]) begin
                            n_bad++;
                            $display("FAIL b_ch%0d_data: got %h, required %h", c, got, exp_b[c][rd_b[c]]);
                        end
                        rd_b[c]++;
                    end
                end
            end
            since_a++;
            if (in_rd_a) begin
                pops_a++;
                n_vec++;
                if (since_a < 3) begin
                    n_bad++;
                    $display("FAIL a_rd_spacing: in_rd %0d cycles after previous, required >= 3", since_a);
                end
                last_gap_a = since_a;
                since_a    = 0;
            end
            if (req_seq != done_seq) begin
                rem = 0;
                for (int c = 0; c < 2; c++) rem += exp_n_a[c] - rd_a[c];
                for (int c = 0; c < 3; c++) rem += exp_n_b[c] - rd_b[c];
                case (req_kind)
                    0:       act = 64'(out_wr_a);
                    1:       act = 64'(tok_cnt_a);
                    2:       act = 64'(tok_cnt_b);
                    3:       act = 64'(pops_a);
                    4:       act = 64'(|{in_rd_a, out_wr_a, out_data_a, tok_cnt_a});
                    5:       act = 64'(|{in_rd_b, out_wr_b, out_data_b, tok_cnt_b});
                    6:       act = 64'(in_rd_a);
                    7:       act = 64'(out_wr_b);
                    8:       act = 64'(last_gap_a);
                    default: act = 64'(rem);
                endcase
                n_vec++;
                if (act !== req_exp) begin
                    n_bad++;
                    $display("FAIL %s: got %0h, required %0h", req_name, act, req_exp);
                end
                done_seq = req_seq;
            end
        end
    end

    task automatic check(input int kind, input logic [63:0] exp, input string name);
        req_kind = kind;
        req_exp  = exp;
        req_name = name;
        req_seq++;
        @(negedge clk);
        #1;
        if (done_seq != req_seq) begin
            $display("FAIL %s: check request not serviced by monitor", name);
            $fatal(1);
        end
    endtask

    task automatic push_a(input logic [15:0] v);
        src_a[avail_a] = v;
        avail_a++;
        for (int c = 0; c < 2; c++) begin
            exp_a[c][exp_n_a[c]] = v;
            exp_n_a[c]++;
        end
    endtask

    // Token that will be popped but then discarded by reset: no writes expected.
    task automatic push_a_drop(input logic [15:0] v);
        src_a[avail_a] = v;
        avail_a++;
    endtask

    task automatic push_b(input logic [15:0] v);
        src_b[avail_b] = v;
        avail_b++;
        exp_b[rr_b][exp_n_b[rr_b]] = v;
        exp_n_b[rr_b]++;
        rr_b = (rr_b + 1) % 3;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        cyc(2);
        check(4, 64'd0, "a_reset_outputs_zero");
        check(5, 64'd0, "b_reset_outputs_zero");
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        check(6, 64'd0, "a_idle_no_rd");

        // Broadcast single token, no backpressure
        push_a(16'hA5A5);
        cyc(1);
        check(6, 64'd1, "a_rd_pulse_high");
        cyc(1);
        check(6, 64'd0, "a_rd_pulse_low");
        cyc(2);
        check(0, 64'd3, "a_broadcast_wr");
        cyc(1);
        check(0, 64'd0, "a_broadcast_wr_pulse_end");
        check(1, 64'd1, "a_tok_cnt_after_1");
        cyc(3);

        // Backpressure on channel 1
        out_full_a = 2'b10;
        push_a(16'h1234);
        cyc(4);
        check(0, 64'd1, "a_bp_ch0_only");
        cyc(9);
        check(0, 64'd0, "a_bp_no_rewrite");
        check(1, 64'd1, "a_bp_tok_cnt_held");
        cyc(1);
        out_full_a = 2'b00;
        cyc(1);
        check(0, 64'd2, "a_bp_ch1_release");
        check(1, 64'd2, "a_bp_tok_cnt_done");
        cyc(3);

        // Round-robin on the N=3 instance
        for (int i = 1; i <= 4; i++) push_b(16'(i));
        cyc(4);
        check(7, 64'd1, "b_rr_first_ch0");
        cyc(3);
        check(7, 64'd2, "b_rr_second_ch1");
        cyc(12);
        check(2, 64'd4, "b_tok_cnt_4");

        // Streaming 8 tokens back to back
        for (int i = 0; i < 8; i++) push_a(16'h4000 + 16'(i * 17));
        cyc(8 * 3 + 10);
        check(8, 64'd3, "a_stream_rd_period");
        check(3, 64'd10, "a_stream_pop_count");
        check(1, 64'd10, "a_stream_tok_cnt");
        check(9, 64'd0, "all_expected_delivered");

        // Reset while a token is stuck in SEND
        out_full_a = 2'b11;
        push_a_drop(16'hDEAD);
        cyc(8);
        rst_n = 1'b0;
        check(4, 64'd0, "a_midreset_outputs_zero");
        cyc(2);
        out_full_a = 2'b00;
        rst_n = 1'b1;
        cyc(10);
        check(1, 64'd0, "a_after_reset_tok_cnt");
        check(3, 64'd11, "a_after_reset_pop_count");

        // Counter wrap on the CNT_W=4 instance
        for (int i = 0; i < 17; i++) push_a(16'h6000 + 16'(i));
        cyc(17 * 3 + 10);
        check(1, 64'd1, "a_tok_cnt_wrap");
        check(3, 64'd28, "a_wrap_pop_count");
        check(9, 64'd0, "all_expected_delivered_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
